// File: rtl/tsn_tx_pkg.sv
// Shared definitions for the RGMII transmit scheduler: line-state encoding,
// fixed line nibbles and frame-source identifiers.
package tsn_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRE,
        ST_SFD,
        ST_DLO,
        ST_DHI,
        ST_IFG
    } tx_state_t;

    localparam logic [3:0] PRE_NIB = 4'h5;
    localparam logic [3:0] SFD_NIB = 4'hD;

    localparam logic SRC_PTP = 1'b0;
    localparam logic SRC_BE  = 1'b1;

endpackage

// File: rtl/rgmii_tx_arb.sv
// Two-way strict-priority arbiter; the grant is held until the frame
// owner's release and never changes while held.
module rgmii_tx_arb
    import tsn_tx_pkg::*;
(
    input  logic       rgmii_txclk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       arb_en,
    input  logic       rel,
    output logic       win,
    output logic [1:0] gnt
);

    always_comb begin
        win = arb_en & (|req);
    end

    always_ff @(posedge rgmii_txclk) begin
        if (rst || rel) begin
            gnt <= 2'b00;
        end else if (win && (gnt == 2'b00)) begin
            gnt <= req[SRC_PTP] ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/rgmii_tx_sched.sv
// RGMII transmit scheduler: arbitrates two frame sources and produces the
// nibble line sequence IFG, preamble, SFD, payload (low nibble first).
module rgmii_tx_sched
    import tsn_tx_pkg::*;
#(
    parameter int IFG_BYTES = 12,
    parameter int PRE_BYTES = 7
) (
    input  logic        rgmii_txclk,
    input  logic        rst,
    input  logic [1:0]  req,
    output logic [1:0]  gnt,
    input  logic [15:0] src_data,
    input  logic [1:0]  src_valid,
    input  logic [1:0]  src_last,
    output logic [1:0]  src_ready,
    output logic        rgmii_txctrl,
    output logic [3:0]  rgmii_txdata,
    output logic        sfd_pulse,
    output logic        sfd_src,
    output logic        underrun,
    output logic [15:0] frame_cnt
);

    localparam int IFG_CYC = 2 * IFG_BYTES;
    localparam int PRE_CYC = 2 * PRE_BYTES + 1;
    localparam int CNT_MAX = (IFG_CYC > PRE_CYC) ? IFG_CYC : PRE_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] IFG_LD  = CNT_W'(IFG_CYC);
    localparam logic [CNT_W-1:0] PRE_LD  = CNT_W'(PRE_CYC);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    tx_state_t        state_q, state_n;
    logic [CNT_W-1:0] cnt_q, cnt_n;
    logic [7:0]       byte_p0;
    logic             last_p0;

    logic       sel, sel_valid, sel_last;
    logic [7:0] sel_data;
    logic       ready_en, accept, abort, done, arb_en, win;

    rgmii_tx_arb u_arb (
        .rgmii_txclk (rgmii_txclk),
        .rst         (rst),
        .req         (req),
        .arb_en      (arb_en),
        .rel         (done | abort),
        .win         (win),
        .gnt         (gnt)
    );

    // Only the granted lane is looked at; the other source is ignored.
    always_comb begin
        sel       = gnt[SRC_BE];
        sel_data  = sel ? src_data[15:8] : src_data[7:0];
        sel_valid = src_valid[sel];
        sel_last  = src_last[sel];
    end

    always_comb begin
        state_n  = state_q;
        cnt_n    = cnt_q;
        ready_en = 1'b0;
        accept   = 1'b0;
        abort    = 1'b0;
        done     = 1'b0;
        arb_en   = 1'b0;
        case (state_q)
            ST_IFG: begin
                if (cnt_q == CNT_ONE) begin
                    arb_en = 1'b1;
                    if (win) begin
                        state_n = ST_PRE;
                        cnt_n   = PRE_LD;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end else begin
                    cnt_n = cnt_q - CNT_ONE;
                end
            end
            ST_IDLE: begin
                arb_en = 1'b1;
                if (win) begin
                    state_n = ST_PRE;
                    cnt_n   = PRE_LD;
                end
            end
            ST_PRE: begin
                if (cnt_q == CNT_ONE) state_n = ST_SFD;
                else                  cnt_n   = cnt_q - CNT_ONE;
            end
            ST_SFD: begin
                ready_en = 1'b1;
                accept   = sel_valid;
                abort    = ~sel_valid;
            end
            ST_DLO: begin
                state_n = ST_DHI;
            end
            ST_DHI: begin
                if (last_p0) begin
                    done = 1'b1;
                end else begin
                    ready_en = 1'b1;
                    accept   = sel_valid;
                    abort    = ~sel_valid;
                end
            end
            default: begin
                state_n = ST_IFG;
                cnt_n   = IFG_LD;
            end
        endcase
        if (accept) begin
            state_n = ST_DLO;
        end
        // Frame end and underrun both restart the full gap.
        if (done || abort) begin
            state_n = ST_IFG;
            cnt_n   = IFG_LD;
        end
    end

    always_comb begin
        src_ready = ready_en ? gnt : 2'b00;
    end

    // Accepted byte is held for its two line nibbles.
    always_ff @(posedge rgmii_txclk) begin
        if (accept) begin
            byte_p0 <= sel_data;
        end
    end

    always_ff @(posedge rgmii_txclk) begin
        if (rst) begin
            state_q      <= ST_IFG;
            cnt_q        <= IFG_LD;
            last_p0      <= 1'b0;
            rgmii_txctrl <= 1'b0;
            rgmii_txdata <= 4'h0;
            sfd_pulse    <= 1'b0;
            sfd_src      <= 1'b0;
            underrun     <= 1'b0;
            frame_cnt    <= 16'h0000;
        end else begin
            state_q      <= state_n;
            cnt_q        <= cnt_n;
            underrun     <= abort;
            sfd_pulse    <= (state_n == ST_SFD);
            rgmii_txctrl <= (state_n == ST_PRE) || (state_n == ST_SFD) ||
                            (state_n == ST_DLO) || (state_n == ST_DHI);
            if (accept) begin
                last_p0 <= sel_last;
            end
            if (state_n == ST_SFD) begin
                sfd_src <= sel;
            end
            if (done) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
            case (state_n)
                ST_PRE:  rgmii_txdata <= PRE_NIB;
                ST_SFD:  rgmii_txdata <= SFD_NIB;
                ST_DLO:  rgmii_txdata <= sel_data[3:0];
                ST_DHI:  rgmii_txdata <= byte_p0[7:4];
                default: rgmii_txdata <= 4'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_rgmii_tx_sched.sv
// Directed bench for rgmii_tx_sched: a per-cycle expectation table for one
// frame plus hand-written sequences for arbitration, underrun, reset and wrap.
module tb_rgmii_tx_sched;

    localparam int IFG_BYTES = 12;
    localparam int PRE_BYTES = 7;

    logic        rgmii_txclk = 1'b0;
    logic        rst;
    logic [1:0]  req, gnt;
    logic [15:0] src_data;
    logic [1:0]  src_valid, src_last, src_ready;
    logic        rgmii_txctrl;
    logic [3:0]  rgmii_txdata;
    logic        sfd_pulse, sfd_src, underrun;
    logic [15:0] frame_cnt;

    rgmii_tx_sched #(.IFG_BYTES(IFG_BYTES), .PRE_BYTES(PRE_BYTES)) dut (
        .rgmii_txclk  (rgmii_txclk),
        .rst          (rst),
        .req          (req),
        .gnt          (gnt),
        .src_data     (src_data),
        .src_valid    (src_valid),
        .src_last     (src_last),
        .src_ready    (src_ready),
        .rgmii_txctrl (rgmii_txctrl),
        .rgmii_txdata (rgmii_txdata),
        .sfd_pulse    (sfd_pulse),
        .sfd_src      (sfd_src),
        .underrun     (underrun),
        .frame_cnt    (frame_cnt)
    );

    always #5 rgmii_txclk = ~rgmii_txclk;

    typedef struct packed {
        logic [1:0] rq;
        logic [1:0] vl;
        logic       ctrl;
        logic [3:0] dat;
        logic       sfd;
        logic [1:0] g;
    } vec_t;

    int         n_vec = 0;
    int         n_fail = 0;
    logic [7:0] fr0[$];
    logic [7:0] fr1[$];
    int         p0 = 0;
    int         p1 = 0;
    logic [1:0] req_v = 2'b00;
    logic [1:0] valid_v = 2'b00;
    logic       rst_v = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // One clock: apply inputs, note byte handshakes, end on the next negedge.
    task automatic cyc();
        logic [1:0] acc;
        rst       = rst_v;
        req       = req_v;
        src_valid = valid_v;
        src_data[7:0]  = (p0 < fr0.size()) ? fr0[p0] : 8'h00;
        src_data[15:8] = (p1 < fr1.size()) ? fr1[p1] : 8'h00;
        src_last[0]    = (p0 == fr0.size() - 1);
        src_last[1]    = (p1 == fr1.size() - 1);
        #1;
        acc = src_ready & src_valid;
        @(negedge rgmii_txclk);
        if (acc[0]) p0++;
        if (acc[1]) p1++;
        if (gnt[0]) req_v[0] = 1'b0;
        if (gnt[1]) req_v[1] = 1'b0;
    endtask

    task automatic settle(input string name);
        int k = 0;
        while ((gnt != 2'b00 || req_v != 2'b00 || rgmii_txctrl) && k < 400) begin
            cyc();
            k++;
        end
        chk(name, (k < 400), 1);
        repeat (2 * IFG_BYTES + 1) cyc();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tab[$];
        logic [3:0] nibs[6];
        logic [3:0] pre_nibs[6];
        int c, sfd0, sfd1, last0, rise1, low;
        logic [3:0] first0;
        logic seen, pre_gnt;

        rst = 1'b1; req = 2'b00; src_valid = 2'b00; src_last = 2'b00; src_data = 16'h0;
        @(negedge rgmii_txclk);
        cyc();
        cyc();
        chk("rst txctrl", rgmii_txctrl, 0);
        chk("rst txdata", rgmii_txdata, 0);
        chk("rst gnt", gnt, 0);
        chk("rst ready", src_ready, 0);
        chk("rst pulses", {sfd_pulse, sfd_src, underrun}, 0);
        chk("rst frame_cnt", frame_cnt, 0);
        rst_v = 1'b0;
        repeat (2 * IFG_BYTES + 1) cyc();

        // Single frame from source 1: 0x12, 0x34, 0xA5.
        nibs = '{4'h2, 4'h1, 4'h4, 4'h3, 4'h5, 4'hA};
        tab.push_back('{2'b10, 2'b11, 1'b1, 4'h5, 1'b0, 2'b10});
        for (int i = 1; i < 2 * PRE_BYTES + 1; i++)
            tab.push_back('{2'b00, 2'b11, 1'b1, 4'h5, 1'b0, 2'b10});
        tab.push_back('{2'b00, 2'b11, 1'b1, 4'hD, 1'b1, 2'b10});
        for (int i = 0; i < 6; i++)
            tab.push_back('{2'b00, 2'b11, 1'b1, nibs[i], 1'b0, 2'b10});
        for (int i = 0; i < 2 * IFG_BYTES + 1; i++)
            tab.push_back('{2'b00, 2'b11, 1'b0, 4'h0, 1'b0, 2'b00});
        fr1 = '{8'h12, 8'h34, 8'hA5}; p1 = 0;
        for (int i = 0; i < tab.size(); i++) begin
            req_v   = tab[i].rq;
            valid_v = tab[i].vl;
            cyc();
            chk($sformatf("single[%0d] ctrl/data/sfd/gnt", i),
                {rgmii_txctrl, rgmii_txdata, sfd_pulse, gnt},
                {tab[i].ctrl, tab[i].dat, tab[i].sfd, tab[i].g});
            if (tab[i].sfd) chk("single sfd_src", sfd_src, 1);
        end
        chk("single frame_cnt", frame_cnt, 1);

        // Simultaneous requests: source 0 first, then source 1 after the gap.
        fr0 = '{8'h0F}; p0 = 0; fr1 = '{8'hF0}; p1 = 0;
        req_v = 2'b11; valid_v = 2'b11;
        c = 0; sfd0 = -1; sfd1 = -1; last0 = -1; rise1 = -1; first0 = 4'h0;
        while (sfd1 < 0 && c < 300) begin
            cyc();
            c++;
            if (sfd_pulse && !sfd_src && sfd0 < 0) sfd0 = c;
            if (sfd0 >= 0 && c == sfd0 + 1) first0 = rgmii_txdata;
            if (rgmii_txctrl && gnt == 2'b01) last0 = c;
            if (rgmii_txctrl && gnt == 2'b10 && rise1 < 0) rise1 = c;
            if (sfd_pulse && sfd_src) sfd1 = c;
        end
        chk("simul src0 first", (sfd0 >= 0 && sfd0 < sfd1), 1);
        chk("simul src0 low nibble", first0, 4'hF);
        chk("simul idle gap", rise1 - last0 - 1, 2 * IFG_BYTES);
        chk("simul src1 sfd delay", sfd1 - last0 - 1, 2 * IFG_BYTES + 2 * PRE_BYTES + 1);
        settle("simul drain");
        chk("simul frame_cnt", frame_cnt, 3);

        // Underrun in the DHI cycle of the second byte.
        fr1 = '{8'h11, 8'h22, 8'h33}; p1 = 0;
        req_v = 2'b10; valid_v = 2'b10;
        c = 0;
        while (!sfd_pulse && c < 100) begin cyc(); c++; end
        chk("urun sfd seen", sfd_pulse, 1);
        repeat (4) cyc();
        chk("urun DHI nibble", {rgmii_txctrl, rgmii_txdata}, {1'b1, 4'h2});
        valid_v = 2'b00;
        cyc();
        chk("urun txctrl", rgmii_txctrl, 0);
        chk("urun pulse", underrun, 1);
        chk("urun gnt", gnt, 0);
        chk("urun frame_cnt", frame_cnt, 3);
        fr1 = '{8'h5A}; p1 = 0; req_v = 2'b10; valid_v = 2'b10;
        low = 1;
        cyc();
        chk("urun pulse width", underrun, 0);
        while (!rgmii_txctrl && low < 100) begin low++; cyc(); end
        chk("urun ifg", low, 2 * IFG_BYTES);
        settle("urun drain");
        chk("urun recover frame_cnt", frame_cnt, 4);

        // Reset asserted during the preamble.
        fr0 = '{8'h77}; p0 = 0; req_v = 2'b01; valid_v = 2'b01;
        cyc();
        chk("rstmid pre", {rgmii_txctrl, rgmii_txdata}, {1'b1, 4'h5});
        repeat (2) cyc();
        rst_v = 1'b1;
        cyc();
        rst_v = 1'b0;
        chk("rstmid txctrl", rgmii_txctrl, 0);
        chk("rstmid gnt", gnt, 0);
        chk("rstmid frame_cnt", frame_cnt, 0);
        req_v = 2'b01; p0 = 0;
        low = 1; seen = sfd_pulse;
        while (!rgmii_txctrl && low < 100) begin
            cyc();
            seen = seen | sfd_pulse;
            if (!rgmii_txctrl) low++;
        end
        chk("rstmid no sfd", seen, 0);
        chk("rstmid ifg", low, 2 * IFG_BYTES);
        chk("rstmid regrant", gnt, 2'b01);
        settle("rstmid drain");
        chk("rstmid frame_cnt after", frame_cnt, 1);

        // Source 0 requests during a source-1 payload: no preemption.
        fr1 = '{8'hA1, 8'hB2, 8'hC3}; p1 = 0; fr0 = '{8'hE7}; p0 = 0;
        req_v = 2'b10; valid_v = 2'b11;
        pre_nibs = '{4'h1, 4'hA, 4'h2, 4'hB, 4'h3, 4'hC};
        c = 0;
        while (!sfd_pulse && c < 100) begin cyc(); c++; end
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i == 0) req_v[0] = 1'b1;
            chk($sformatf("preempt nib[%0d] ctrl/data/gnt", i),
                {rgmii_txctrl, rgmii_txdata, gnt}, {1'b1, pre_nibs[i], 2'b10});
        end
        cyc();
        low = 0; pre_gnt = 1'b0;
        while (!rgmii_txctrl && low < 100) begin
            low++;
            if (gnt != 2'b00) pre_gnt = 1'b1;
            cyc();
        end
        chk("preempt gap", low, 2 * IFG_BYTES);
        chk("preempt early gnt", pre_gnt, 0);
        chk("preempt src0 gnt", gnt, 2'b01);
        settle("preempt drain");
        chk("preempt frame_cnt", frame_cnt, 3);

        // Counter wrap.
        force dut.frame_cnt = 16'hFFFF;
        cyc();
        release dut.frame_cnt;
        chk("wrap preset", frame_cnt, 16'hFFFF);
        fr0 = '{8'h3C}; p0 = 0; req_v = 2'b01; valid_v = 2'b01;
        settle("wrap drain");
        chk("wrap frame_cnt", frame_cnt, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/rgmii_tx_sched.md
# rgmii_tx_sched

Synthesizable RGMII transmit scheduler for the TSN switch egress path. It arbitrates between two frame sources: source 0 is the PTP event path and source 1 is best-effort. For each frame it generates the nibble-level line sequence: inter-frame gap, preamble, SFD, then payload low nibble first. It also emits an SFD strobe so the TSU can capture egress timestamps.

## Interface
- IFG_BYTES, 12: minimum inter-frame gap in bytes; the line idles for 2*IFG_BYTES cycles.
- PRE_BYTES, 7: preamble bytes of 0x55 ahead of the SFD byte.
- rgmii_txclk  in  1  nibble clock; all logic is on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- req  in  2  per-source frame request, held until the source sees gnt.
- gnt  out  2  one-hot; high from grant until the frame's last nibble or an underrun.
- src_data  in  16  byte per source; source i occupies [8i+7:8i].
- src_valid  in  2  per-source byte valid.
- src_last  in  2  per-source marker for the final byte of the frame.
- src_ready  out  2  byte accept strobe; only the granted source's bit can be high.
- rgmii_txctrl  out  1  TX_EN.
- rgmii_txdata  out  4  line nibble.
- sfd_pulse  out  1  high during the cycle in which the SFD nibble 0xD is on the line.
- sfd_src  out  1  granted source, valid while sfd_pulse is high.
- underrun  out  1  one-cycle pulse when a frame is aborted.
- frame_cnt  out  16  count of completed frames; wraps at 16 bits.

## Operation
- The state register describes what is on the line this cycle. States are IDLE, PRE, SFD, DLO, DHI and IFG.
- Reset values:
  - state=IFG with the full count loaded;
  - txctrl=0, txdata=0;
  - gnt=0, src_ready=0, sfd_pulse=0, sfd_src=0, underrun=0;
  - frame_cnt=0.
- IFG: txctrl=0 and txdata=0 for 2*IFG_BYTES cycles, then IDLE.
- Arbitration is strict priority: req[0] wins over req[1]. It is evaluated in IDLE and in the last IFG cycle.
  - Win: gnt is set and the next state is PRE.
  - No request: the block stays in IDLE.
- PRE: txctrl=1, txdata=0x5 for 2*PRE_BYTES+1 cycles, then SFD.
- SFD: txctrl=1, txdata=0xD, sfd_pulse=1.
- Byte acceptance:
  - src_ready[g] is combinational. It is high in SFD, and in DHI unless the last byte has already been accepted.
  - A byte is accepted when src_ready and src_valid are both high. The byte and its last flag are registered, and the next state is DLO.
- DLO: txctrl=1, txdata=byte[3:0]; next state is DHI.
- DHI: txctrl=1, txdata=byte[7:4]. If the last byte has been sent, the next state is IFG, gnt is cleared and frame_cnt increments.
- Underrun: src_ready is high while src_valid is low (in SFD or DHI). On the next edge:
  - txctrl=0;
  - underrun pulses;
  - gnt clears;
  - state becomes IFG with the full count;
  - frame_cnt does not increment.
- The data, valid and last inputs of the non-granted source are ignored.

## Timing
- Grant to first line nibble: 1 cycle. A request in IDLE at cycle t gives txctrl=1 at t+1.
- Frame on the line: 2*PRE_BYTES+1 preamble cycles, 1 SFD cycle, then 2 cycles per byte.
- Back-to-back frames: txctrl is low for exactly 2*IFG_BYTES cycles when the next request is already present.
- All outputs except src_ready are registered.
- A request arriving during PRE, SFD or data states does not preempt the current frame.
- Reset asserted mid-frame: txctrl=0 at the next edge, gnt clears, and the full IFG is served before any grant.
- frame_cnt wraps from 0xFFFF to 0x0000.

## Structure
- Shared package (tsn_tx_pkg) holds:
  - the state encoding enum;
  - the preamble and SFD nibble constants 4'h5 and 4'hD;
  - the source IDs SRC_PTP=0 and SRC_BE=1.
- One sub-module, rgmii_tx_arb: the 2-way strict-priority arbiter with a hold-until-release grant.
- The state machine and counters stay in the top module.

## Test plan
- Single frame:
  - Stimulus: req[1], 3 bytes 0x12, 0x34, 0xA5 (last on 0xA5), valid always high.
  - Required: 15×0x5, 0xD, then 2,1,4,3,5,A with txctrl=1, then 24 cycles with txctrl=0; frame_cnt=1; sfd_src=1.
- Simultaneous requests:
  - Stimulus: req=2'b11 in IDLE.
  - Required: source 0's frame first; source 1's SFD exactly 24+15 cycles after source 0's last nibble.
- Underrun:
  - Stimulus: valid drops in the DHI cycle of the second byte.
  - Required: txctrl=0 on the next cycle, underrun one cycle high, gnt=0, frame_cnt unchanged, IFG of 24 cycles.
- Reset mid-frame:
  - Stimulus: rst during PRE.
  - Required: txctrl=0 on the next edge, no sfd_pulse, and with req held the next txctrl rise 24 cycles after reset release.
- Preemption attempt:
  - Stimulus: req[0] rises during a source-1 payload.
  - Required: source 1 completes unaffected; source 0 is granted in the last IFG cycle.
- Counter wrap:
  - Stimulus: frame_cnt forced to 0xFFFF, then one completed frame.
  - Required: frame_cnt=0x0000.
